// File: rtl/fwvip_wb_txn_monitor.sv
// Passive Wishbone monitor: turns each completed beat into a record and queues it in a FWFT FIFO.
// Optional timestamps are built only when FWVIP_WB_TXN_MON_TIMESTAMP_EN is defined.
module fwvip_wb_txn_monitor #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LAT_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [ADDR_WIDTH-1:0]         madr,
    input  logic [DATA_WIDTH-1:0]         mdat_w,
    input  logic [DATA_WIDTH-1:0]         mdat_r,
    input  logic [DATA_WIDTH/8-1:0]       msel,
    input  logic                          mwe,
    input  logic                          mcyc,
    input  logic                          mstb,
    input  logic                          mack,
    input  logic                          merr,
    output logic                          txn_valid,
    input  logic                          txn_ready,
    output logic [ADDR_WIDTH-1:0]         txn_adr,
    output logic [DATA_WIDTH-1:0]         txn_dat,
    output logic [DATA_WIDTH/8-1:0]       txn_sel,
    output logic                          txn_we,
    output logic                          txn_err,
    output logic [LAT_WIDTH-1:0]          txn_lat,
    output logic [31:0]                   txn_ts,
    output logic [15:0]                   drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] adr;
        logic [DATA_WIDTH-1:0] dat;
        logic [SW-1:0]         sel;
        logic                  we;
        logic                  err;
        logic [LAT_WIDTH-1:0]  lat;
    } rec_t;

    state_t               state, state_n;
    logic [LAT_WIDTH-1:0] lat, lat_n, rec_lat;
    logic                 active, term;
    rec_t                 new_rec;
    rec_t                 mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 pop, full, push_ok, drop;

    assign active = mcyc && mstb;
    assign term   = active && (mack || merr);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            lat   <= '0;
        end else begin
            state <= state_n;
            lat   <= lat_n;
        end
    end

    always_comb begin
        state_n = state;
        lat_n   = lat;
        rec_lat = '0;
        case (state)
            S_IDLE: begin
                if (active && !term) begin
                    state_n = S_WAIT;
                    lat_n   = LAT_WIDTH'(1);
                end
            end
            S_WAIT: begin
                if (term) begin
                    rec_lat = lat;
                    state_n = S_IDLE;
                    lat_n   = '0;
                end else if (active) begin
                    if (lat != '1) lat_n = lat + LAT_WIDTH'(1);
                end else begin
                    state_n = S_IDLE;
                    lat_n   = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                lat_n   = '0;
            end
        endcase
    end

    always_comb begin
        new_rec.adr = madr;
        new_rec.dat = mwe ? mdat_w : mdat_r;
        new_rec.sel = msel;
        new_rec.we  = mwe;
        new_rec.err = merr;
        new_rec.lat = rec_lat;
    end

    assign txn_valid = (fifo_level != '0);
    assign pop       = txn_valid && txn_ready;
    assign full      = (fifo_level == LW'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = term && (!full || pop);
    assign drop      = term && full && !pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_cnt   <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= new_rec;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign txn_adr = mem[rd_ptr].adr;
    assign txn_dat = mem[rd_ptr].dat;
    assign txn_sel = mem[rd_ptr].sel;
    assign txn_we  = mem[rd_ptr].we;
    assign txn_err = mem[rd_ptr].err;
    assign txn_lat = mem[rd_ptr].lat;

`ifdef FWVIP_WB_TXN_MON_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_mem [FIFO_DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) ts_mem[i] <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (push_ok) ts_mem[wr_ptr] <= ts_cnt;
        end
    end

    assign txn_ts = ts_mem[rd_ptr];
`else
    assign txn_ts = '0;
`endif

endmodule

// File: tb/tb_fwvip_wb_txn_monitor.sv
// Directed self-checking bench for fwvip_wb_txn_monitor (default parameters, FIFO_DEPTH = 4).
module tb_fwvip_wb_txn_monitor;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] madr, mdat_w, mdat_r;
    logic [3:0]  msel;
    logic        mwe, mcyc, mstb, mack, merr;
    logic        txn_valid, txn_ready;
    logic [31:0] txn_adr, txn_dat, txn_ts;
    logic [3:0]  txn_sel;
    logic        txn_we, txn_err;
    logic [15:0] txn_lat, drop_cnt;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fwvip_wb_txn_monitor #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .LAT_WIDTH(16)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .madr(madr), .mdat_w(mdat_w), .mdat_r(mdat_r), .msel(msel),
        .mwe(mwe), .mcyc(mcyc), .mstb(mstb), .mack(mack), .merr(merr),
        .txn_valid(txn_valid), .txn_ready(txn_ready),
        .txn_adr(txn_adr), .txn_dat(txn_dat), .txn_sel(txn_sel),
        .txn_we(txn_we), .txn_err(txn_err), .txn_lat(txn_lat), .txn_ts(txn_ts),
        .drop_cnt(drop_cnt), .fifo_level(fifo_level)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        mcyc = 0; mstb = 0; mack = 0; merr = 0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] dw, input logic [31:0] dr,
                        input logic we, input logic ack, input logic err);
        madr = a; mdat_w = dw; mdat_r = dr; msel = 4'hF; mwe = we;
        mcyc = 1; mstb = 1; mack = ack; merr = err;
    endtask

    task automatic pop_one();
        txn_ready = 1;
        tick();
        txn_ready = 0;
    endtask

    logic [31:0] exp_adr [4];
    logic [31:0] exp_dat [4];
    logic [31:0] exp_ts;

    initial begin
        reset_n = 0; txn_ready = 0;
        madr = '0; mdat_w = '0; mdat_r = '0; msel = '0; mwe = 0;
        bus_idle();
        tick(); tick();
        chk("rst_valid", txn_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_adr", txn_adr, 0);
        chk("rst_ts", txn_ts, 0);
        reset_n = 1;
        tick();

        // single-cycle write
        beat(32'h100, 32'hDEADBEEF, 32'h0, 1, 1, 0);
        tick();
        bus_idle();
        chk("wr_valid", txn_valid, 1);
        chk("wr_adr", txn_adr, 32'h100);
        chk("wr_dat", txn_dat, 32'hDEADBEEF);
        chk("wr_sel", txn_sel, 4'hF);
        chk("wr_we", txn_we, 1);
        chk("wr_lat", txn_lat, 0);
        chk("wr_err", txn_err, 0);
        chk("wr_level", fifo_level, 1);
        pop_one();
        chk("wr_pop_valid", txn_valid, 0);

        // read with 3 wait cycles
        beat(32'h104, 32'h0, 32'h12345678, 0, 0, 0);
        tick(); tick(); tick();
        chk("rd_wait_valid", txn_valid, 0);
        mack = 1;
        tick();
        bus_idle();
        chk("rd_valid", txn_valid, 1);
        chk("rd_we", txn_we, 0);
        chk("rd_dat", txn_dat, 32'h12345678);
        chk("rd_lat", txn_lat, 3);
        pop_one();

        // error termination
        beat(32'h200, 32'hCAFE0001, 32'h0, 1, 0, 1);
        tick();
        bus_idle();
        chk("err_adr", txn_adr, 32'h200);
        chk("err_err", txn_err, 1);
        chk("err_lat", txn_lat, 0);
        pop_one();

        // ack and err together
        beat(32'h204, 32'h5, 32'h0, 1, 1, 1);
        tick();
        bus_idle();
        chk("ackerr_err", txn_err, 1);
        pop_one();

        // abort: cyc dropped before ack
        beat(32'h208, 32'h6, 32'h0, 1, 0, 0);
        tick(); tick();
        bus_idle();
        tick(); tick();
        chk("abort_level", fifo_level, 0);
        chk("abort_valid", txn_valid, 0);
        beat(32'h20C, 32'h7, 32'h0, 1, 1, 0);
        tick();
        bus_idle();
        chk("post_abort_lat", txn_lat, 0);
        chk("post_abort_adr", txn_adr, 32'h20C);
        pop_one();

        // overflow: 7 back-to-back beats with no consumer
        for (int i = 0; i < 7; i++) begin
            beat(32'h300 + 32'(i) * 4, 32'(i + 1), 32'h0, 1, 1, 0);
            tick();
        end
        bus_idle();
        chk("ovf_level", fifo_level, 4);
        chk("ovf_drop", drop_cnt, 3);
        chk("ovf_head_adr", txn_adr, 32'h300);
        chk("ovf_head_dat", txn_dat, 32'h1);

        // push and pop together while full
        beat(32'h400, 32'hAA, 32'h0, 1, 1, 0);
        txn_ready = 1;
        tick();
        txn_ready = 0;
        bus_idle();
        chk("full_pp_level", fifo_level, 4);
        chk("full_pp_drop", drop_cnt, 3);
        exp_adr[0] = 32'h304; exp_dat[0] = 32'h2;
        exp_adr[1] = 32'h308; exp_dat[1] = 32'h3;
        exp_adr[2] = 32'h30C; exp_dat[2] = 32'h4;
        exp_adr[3] = 32'h400; exp_dat[3] = 32'hAA;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_adr%0d", i), txn_adr, exp_adr[i]);
            chk($sformatf("drain_dat%0d", i), txn_dat, exp_dat[i]);
            pop_one();
        end
        chk("drain_valid", txn_valid, 0);
        chk("drain_level", fifo_level, 0);

        // level 1 with simultaneous push and pop: new record becomes head
        beat(32'h500, 32'h11, 32'h0, 1, 1, 0);
        tick();
        beat(32'h504, 32'h22, 32'h0, 1, 1, 0);
        txn_ready = 1;
        tick();
        txn_ready = 0;
        bus_idle();
        chk("l1_pp_level", fifo_level, 1);
        chk("l1_pp_adr", txn_adr, 32'h504);
        pop_one();

        // reset mid-WAIT with two records queued
        beat(32'h600, 32'h1, 32'h0, 1, 1, 0);
        tick(); tick();
        beat(32'h604, 32'h0, 32'h0, 0, 0, 0);
        tick(); tick();
        chk("pre_rst_level", fifo_level, 2);
        chk("pre_rst_drop", drop_cnt, 3);
        reset_n = 0;
        #1;
        chk("mid_rst_valid", txn_valid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_adr", txn_adr, 0);
        tick();
        reset_n = 1;
        beat(32'h700, 32'h0, 32'h9ABC, 0, 0, 0);
        tick(); tick();
        mack = 1;
        tick();
        bus_idle();
`ifdef FWVIP_WB_TXN_MON_TIMESTAMP_EN
        exp_ts = 32'd2;
`else
        exp_ts = 32'd0;
`endif
        chk("rel_valid", txn_valid, 1);
        chk("rel_lat", txn_lat, 2);
        chk("rel_dat", txn_dat, 32'h9ABC);
        chk("rel_ts", txn_ts, exp_ts);
        pop_one();
        chk("end_valid", txn_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
